// File: rtl/segment_sampler_pkg.sv
// Shared types and constants for the segment value sampler and its LFSR.
// Latency: n/a (types, constants and a pure combinational helper).
// Backpressure: n/a.
package segment_sampler_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DRAW = 2'd2,
      DONE = 2'd3
   } state_t;

   // Galois taps for x^16+x^14+x^13+x^11+1, right-shifting form.
   localparam logic [15:0] LFSR_TAPS  = 16'hB400;
   localparam logic [15:0] LFSR_RESET = 16'h0001;

   // Smallest 2^k-1 covering rng: smear the top set bit into every lower bit.
   function automatic logic [15:0] mask_from_range(input logic [15:0] rng);
      logic [15:0] m;
      m = rng;
      m = m | (m >> 1);
      m = m | (m >> 2);
      m = m | (m >> 4);
      m = m | (m >> 8);
      return m;
   endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR with seed load (zero seed replaced by LFSR_RESET).
// Latency: new state visible the cycle after load/step.
// Backpressure: none; advances only when step is high, load has priority.
// Ports: in_clock/in_reset (async active-low), load+seed, step, state.
module lfsr16
   import segment_sampler_pkg::*;
(
   input  logic        in_clock,
   input  logic        in_reset,
   input  logic        load,
   input  logic [15:0] seed,
   input  logic        step,
   output logic [15:0] state
);

   always_ff @(posedge in_clock or negedge in_reset) begin
      if (!in_reset) begin
         state <= LFSR_RESET;
      end else if (load) begin
         // An all-zero state would lock the LFSR up forever.
         state <= (seed == 16'h0000) ? LFSR_RESET : seed;
      end else if (step) begin
         state <= (state >> 1) ^ (state[0] ? LFSR_TAPS : 16'h0000);
      end
   end

endmodule

// File: rtl/segment_value_sampler.sv
// Draws a uniform value inside the chosen segment's [lower, upper] bounds.
// Latency: 3 cycles best case, MAX_TRIES+2 worst case, 2 for an empty segment.
// Backpressure: none; in_start is ignored while out_busy is high (no queue).
// Ports: in_clock, in_reset (async active-low), in_seed_load/in_seed,
//        in_start/in_segment_number, in_lower0..3/in_upper0..3,
//        out_value/out_valid/out_error/out_busy.
module segment_value_sampler
   import segment_sampler_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int MAX_TRIES = 8
) (
   input  logic             in_clock,
   input  logic             in_reset,
   input  logic             in_seed_load,
   input  logic [15:0]      in_seed,
   input  logic             in_start,
   input  logic [1:0]       in_segment_number,
   input  logic [WIDTH-1:0] in_lower0,
   input  logic [WIDTH-1:0] in_lower1,
   input  logic [WIDTH-1:0] in_lower2,
   input  logic [WIDTH-1:0] in_lower3,
   input  logic [WIDTH-1:0] in_upper0,
   input  logic [WIDTH-1:0] in_upper1,
   input  logic [WIDTH-1:0] in_upper2,
   input  logic [WIDTH-1:0] in_upper3,
   output logic [WIDTH-1:0] out_value,
   output logic             out_valid,
   output logic             out_error,
   output logic             out_busy
);

   localparam int TW = $clog2(MAX_TRIES + 1);

   state_t           state;
   logic [WIDTH-1:0] lower_q;
   logic [WIDTH-1:0] upper_q;
   logic [WIDTH-1:0] range_q;
   logic [15:0]      mask_q;
   logic [TW-1:0]    tries_q;
   logic [TW-1:0]    tries_nxt;
   logic [15:0]      lfsr_state;
   logic [15:0]      cand;
   logic [WIDTH-1:0] sel_lower;
   logic [WIDTH-1:0] sel_upper;
   logic [WIDTH-1:0] diff;

   always_comb begin
      sel_lower = in_lower0;
      sel_upper = in_upper0;
      case (in_segment_number)
         2'd1:    begin sel_lower = in_lower1; sel_upper = in_upper1; end
         2'd2:    begin sel_lower = in_lower2; sel_upper = in_upper2; end
         2'd3:    begin sel_lower = in_lower3; sel_upper = in_upper3; end
         default: begin sel_lower = in_lower0; sel_upper = in_upper0; end
      endcase
   end

   assign diff      = upper_q - lower_q;
   // Full 16-bit candidate; mask_q has zeros above WIDTH so the top bits are 0.
   assign cand      = lfsr_state & mask_q;
   assign tries_nxt = tries_q + 1'b1;

   lfsr16 u_lfsr (
      .in_clock (in_clock),
      .in_reset (in_reset),
      .load     ((state == IDLE) && in_seed_load && !in_start),
      .seed     (in_seed),
      .step     (state == DRAW),
      .state    (lfsr_state)
   );

   always_ff @(posedge in_clock or negedge in_reset) begin
      if (!in_reset) begin
         state     <= IDLE;
         lower_q   <= '0;
         upper_q   <= '0;
         range_q   <= '0;
         mask_q    <= '0;
         tries_q   <= '0;
         out_value <= '0;
         out_error <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_start) begin
                  lower_q <= sel_lower;
                  upper_q <= sel_upper;
                  state   <= CALC;
               end
            end
            CALC: begin
               if (lower_q > upper_q) begin
                  out_value <= lower_q;
                  out_error <= 1'b1;
                  state     <= DONE;
               end else begin
                  range_q <= diff;
                  mask_q  <= mask_from_range(16'(diff));
                  tries_q <= '0;
                  state   <= DRAW;
               end
            end
            DRAW: begin
               if (cand <= 16'(range_q)) begin
                  out_value <= lower_q + cand[WIDTH-1:0];
                  out_error <= 1'b0;
                  state     <= DONE;
               end else begin
                  tries_q <= tries_nxt;
                  // mask <= 2*range+1, so cand>>1 <= range: always in bounds.
                  if (tries_nxt == TW'(MAX_TRIES)) begin
                     out_value <= lower_q + WIDTH'(cand >> 1);
                     out_error <= 1'b0;
                     state     <= DONE;
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign out_valid = (state == DONE);
   assign out_busy  = (state != IDLE);

endmodule
